// File: rtl/lpm_ram_tcam_if.sv
// Write/lookup signal bundle for lpm_ram_tcam.
// Defining LPM_TCAM_ENCODED_EN adds the encoded match_addr output.
interface lpm_ram_tcam_if #(
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = 5,
    parameter int KEY_WIDTH      = 32
);
    logic                      start_write;
    logic [LUT_DEPTH_BITS-1:0] waddr;
    logic [KEY_WIDTH-1:0]      wdata;
    logic [KEY_WIDTH-1:0]      wcare;
    logic [KEY_WIDTH-1:0]      lookup_data;
    logic [LUT_DEPTH-1:0]      match_lines;
    logic                      ready;
    logic                      match_found;

`ifdef LPM_TCAM_ENCODED_EN
    logic [LUT_DEPTH_BITS-1:0] match_addr;

    modport master (
        output start_write, waddr, wdata, wcare, lookup_data,
        input  match_lines, ready, match_found, match_addr
    );
    modport slave (
        input  start_write, waddr, wdata, wcare, lookup_data,
        output match_lines, ready, match_found, match_addr
    );
`else
    modport master (
        output start_write, waddr, wdata, wcare, lookup_data,
        input  match_lines, ready, match_found
    );
    modport slave (
        input  start_write, waddr, wdata, wcare, lookup_data,
        output match_lines, ready, match_found
    );
`endif
endinterface

// File: rtl/lpm_ram_tcam.sv
// RAM-based ternary CAM: one-cycle lookups, entry writes swept row by row over the slice RAMs.
// Optional LPM_TCAM_ENCODED_EN adds a lowest-index match_addr encoder.
module lpm_ram_tcam #(
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = 5,
    parameter int KEY_WIDTH      = 32,
    parameter int SLICE_BITS     = 4
) (
    input  logic           clk,
    input  logic           reset,
    lpm_ram_tcam_if.slave  bus
);
    localparam int SLICES = KEY_WIDTH / SLICE_BITS;
    localparam int ROWS   = 1 << SLICE_BITS;
    localparam logic [SLICE_BITS-1:0] LAST_ROW = '1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]                r_state;
    logic [SLICE_BITS-1:0]     r_cnt;
    logic [LUT_DEPTH_BITS-1:0] r_waddr;
    logic [KEY_WIDTH-1:0]      r_wdata;
    logic [KEY_WIDTH-1:0]      r_wcare;
    logic                      r_valid;

    logic                                w_we;
    logic [SLICE_BITS-1:0]               w_wRow;
    logic [SLICES-1:0][LUT_DEPTH-1:0]    w_rows;
    logic [LUT_DEPTH-1:0]                w_andRows;
    logic [LUT_DEPTH-1:0]                w_matchLines;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wcare <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_IDLE);
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ROW) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.start_write) begin
                        r_waddr <= bus.waddr;
                        r_wdata <= bus.wdata;
                        r_wcare <= bus.wcare;
                        r_cnt   <= '0;
                        r_state <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ROW) r_state <= ST_DRAIN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The sweep writes back the row it read one cycle earlier, so it never reads and writes the same row.
    always_comb begin
        w_we   = 1'b0;
        w_wRow = r_cnt;
        case (r_state)
            ST_INIT: w_we = 1'b1;
            ST_SWEEP: begin
                w_we   = (r_cnt != '0);
                w_wRow = r_cnt - 1'b1;
            end
            ST_DRAIN: begin
                w_we   = 1'b1;
                w_wRow = LAST_ROW;
            end
            default: w_we = 1'b0;
        endcase
    end

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        logic [LUT_DEPTH-1:0]  r_mem [ROWS];
        logic [LUT_DEPTH-1:0]  r_rdata;
        logic [SLICE_BITS-1:0] w_rAddr;
        logic [SLICE_BITS-1:0] w_sliceData;
        logic [SLICE_BITS-1:0] w_sliceCare;
        logic                  w_bit;
        logic [LUT_DEPTH-1:0]  w_wData;

        assign w_sliceData = r_wdata[s*SLICE_BITS +: SLICE_BITS];
        assign w_sliceCare = r_wcare[s*SLICE_BITS +: SLICE_BITS];
        assign w_bit       = ((w_wRow ^ w_sliceData) & ~w_sliceCare) == '0;
        assign w_rAddr     = (r_state == ST_SWEEP) ? r_cnt
                                                   : bus.lookup_data[s*SLICE_BITS +: SLICE_BITS];

        always_comb begin
            w_wData          = r_rdata;
            w_wData[r_waddr] = w_bit;
            if (r_state == ST_INIT) w_wData = '0;
        end

        always_ff @(posedge clk) begin
            if (w_we) r_mem[w_wRow] <= w_wData;
            r_rdata <= r_mem[w_rAddr];
        end

        assign w_rows[s] = r_rdata;
    end

    always_comb begin
        w_andRows = '1;
        for (int s = 0; s < SLICES; s++) w_andRows &= w_rows[s];
    end

    // Read data only counts when the address came from an idle-cycle lookup.
    assign w_matchLines    = r_valid ? w_andRows : '0;
    assign bus.match_lines = w_matchLines;
    assign bus.match_found = |w_matchLines;
    assign bus.ready       = (r_state == ST_IDLE);

`ifdef LPM_TCAM_ENCODED_EN
    logic [LUT_DEPTH_BITS-1:0] w_matchAddr;

    always_comb begin
        w_matchAddr = '0;
        for (int i = LUT_DEPTH - 1; i >= 0; i--)
            if (w_matchLines[i]) w_matchAddr = LUT_DEPTH_BITS'(i);
    end

    assign bus.match_addr = w_matchAddr;
`else
`endif
endmodule

// File: tb/tb_lpm_ram_tcam.sv
// Self-checking bench for lpm_ram_tcam: table vectors, corner sequences and randomized
// writes/lookups compared against an entry-list reference model.
module tb_lpm_ram_tcam;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    lpm_ram_tcam_if ifc ();

    lpm_ram_tcam dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the list of written entries, matched with plain ternary arithmetic.
    bit          mValid [32];
    logic [31:0] mData  [32];
    logic [31:0] mCare  [32];

    typedef struct {
        bit          isWrite;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] care;
        logic [31:0] key;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkW(logic [4:0] idx, logic [31:0] d, logic [31:0] c);
        vec_t v;
        v.isWrite = 1'b1; v.idx = idx; v.data = d; v.care = c; v.key = '0; v.exp = '0;
        return v;
    endfunction

    function automatic vec_t mkL(logic [31:0] key, logic [31:0] exp);
        vec_t v;
        v.isWrite = 1'b0; v.idx = '0; v.data = '0; v.care = '0; v.key = key; v.exp = exp;
        return v;
    endfunction

    function automatic logic [31:0] modelMatch(logic [31:0] key);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++)
            if (mValid[i] && (((key ^ mData[i]) & ~mCare[i]) == 32'h0)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [4:0] lowestIdx(logic [31:0] m);
        for (int i = 0; i < 32; i++)
            if (m[i]) return 5'(i);
        return 5'd0;
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < 32; i++) begin
            mValid[i] = 1'b0; mData[i] = '0; mCare[i] = '0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic checkLines(input string name, input logic [31:0] exp);
        checkOutput({name, " lines"}, ifc.match_lines, exp);
        checkOutput({name, " found"}, 32'(ifc.match_found), 32'(|exp));
`ifdef LPM_TCAM_ENCODED_EN
        checkOutput({name, " addr"}, 32'(ifc.match_addr), 32'(lowestIdx(exp)));
`endif
    endtask

    task automatic lookupCheck(input string name, input logic [31:0] key, input logic [31:0] exp);
        ifc.lookup_data = key;
        tick();
        checkLines(name, exp);
    endtask

    // Accepts a write and checks that ready returns 18 cycles after the strobe was presented.
    task automatic applyStimulus(input logic [4:0] idx, input logic [31:0] d, input logic [31:0] c);
        int n;
        checkOutput("write ready", 32'(ifc.ready), 32'd1);
        ifc.start_write = 1'b1;
        ifc.waddr = idx; ifc.wdata = d; ifc.wcare = c;
        tick();
        ifc.start_write = 1'b0;
        mValid[idx] = 1'b1; mData[idx] = d; mCare[idx] = c;
        n = 1;
        while (!ifc.ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput("write latency", 32'(n), 32'd18);
    endtask

    task automatic waitInit(input string name);
        int n;
        n = 0;
        while (!ifc.ready && n < 40) begin
            checkOutput({name, " init lines"}, ifc.match_lines, 32'h0);
            ifc.lookup_data = $urandom;
            tick();
            n++;
        end
        checkOutput({name, " init cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        logic [31:0] key, prevExp, care, d;
        int          n;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        ifc.start_write = 1'b0;
        ifc.waddr = '0; ifc.wdata = '0; ifc.wcare = '0;
        ifc.lookup_data = 32'hFFFFFFFF;
        modelClear();

        vecs.push_back(mkW(5'd3, 32'h0A000000, 32'h00FFFFFF));
        vecs.push_back(mkL(32'h0A0102FE, 32'h00000008));
        vecs.push_back(mkL(32'h0B000001, 32'h00000000));
        vecs.push_back(mkW(5'd0, 32'h0A010200, 32'h000000FF));
        vecs.push_back(mkL(32'h0A010203, 32'h00000009));
        vecs.push_back(mkL(32'h0A0103FF, 32'h00000008));
        vecs.push_back(mkL(32'h0A0102AB, 32'h00000009));
        vecs.push_back(mkL(32'h09000000, 32'h00000000));
        vecs.push_back(mkW(5'd5, 32'h0AFFFFFF, 32'h00FFFFFF));
        vecs.push_back(mkL(32'h0A000000, 32'h00000028));
        vecs.push_back(mkW(5'd31, 32'h5A5A5A5A, 32'hFFFFFFFF));
        vecs.push_back(mkL(32'h00000000, 32'h80000000));
        vecs.push_back(mkL(32'hFFFFFFFF, 32'h80000000));
        vecs.push_back(mkL(32'h0A010203, 32'h80000029));
        vecs.push_back(mkW(5'd31, 32'hC0A80001, 32'h00000000));
        vecs.push_back(mkL(32'h00000000, 32'h00000000));
        vecs.push_back(mkL(32'hC0A80001, 32'h80000000));
        vecs.push_back(mkL(32'hC0A80000, 32'h00000000));
        vecs.push_back(mkL(32'h0A010299, 32'h00000029));

        tick(); tick(); tick();
        checkOutput("reset ready", 32'(ifc.ready), 32'd0);
        checkLines("reset", 32'h0);
        reset = 1'b0;
        waitInit("first");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].isWrite) applyStimulus(vecs[i].idx, vecs[i].data, vecs[i].care);
            else lookupCheck($sformatf("vec%0d", i), vecs[i].key, vecs[i].exp);
        end

        // A strobe five cycles into a sweep must be dropped without extending the write.
        ifc.start_write = 1'b1;
        ifc.waddr = 5'd10; ifc.wdata = 32'h12345678; ifc.wcare = 32'h0;
        tick();
        ifc.start_write = 1'b0;
        mValid[10] = 1'b1; mData[10] = 32'h12345678; mCare[10] = 32'h0;
        tick(); tick(); tick(); tick();
        ifc.start_write = 1'b1;
        ifc.waddr = 5'd11; ifc.wdata = 32'h11111111; ifc.wcare = 32'h0;
        tick();
        ifc.start_write = 1'b0;
        n = 6;
        while (!ifc.ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput("ignored write latency", 32'(n), 32'd18);
        lookupCheck("first entry kept", 32'h12345678, 32'h00000400);
        lookupCheck("second entry dropped", 32'h11111111, 32'h00000000);

        // Randomized writes, each followed by back-to-back pipelined lookups.
        for (int w = 0; w < 24; w++) begin
            n = $urandom_range(0, 32);
            care = (n == 32) ? 32'h0 : (32'hFFFFFFFF >> n);
            if ($urandom_range(0, 3) == 0) care = $urandom;
            d = $urandom;
            applyStimulus(5'($urandom_range(0, 31)), d, care);
            ifc.lookup_data = d;
            prevExp = modelMatch(d);
            for (int k = 0; k < 8; k++) begin
                tick();
                checkLines($sformatf("rand w%0d k%0d", w, k), prevExp);
                if (k[0]) key = $urandom;
                else key = mData[$urandom_range(0, 31)] ^ ($urandom & care);
                ifc.lookup_data = key;
                prevExp = modelMatch(key);
            end
            tick();
            checkLines($sformatf("rand w%0d last", w), prevExp);
        end

        // Reset during sweep cycle 8 of a write aborts it and clears every entry.
        ifc.start_write = 1'b1;
        ifc.waddr = 5'd7; ifc.wdata = 32'hAC100000; ifc.wcare = 32'h0000FFFF;
        tick();
        ifc.start_write = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelClear();
        checkOutput("midsweep reset ready", 32'(ifc.ready), 32'd0);
        checkLines("midsweep reset", 32'h0);
        waitInit("second");
        lookupCheck("cleared idx7", 32'hAC100001, modelMatch(32'hAC100001));
        lookupCheck("cleared zero", 32'h00000000, 32'h0);
        lookupCheck("cleared ones", 32'hFFFFFFFF, 32'h0);
        for (int k = 0; k < 6; k++) begin
            key = $urandom;
            lookupCheck($sformatf("cleared rand%0d", k), key, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
